// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port synchronous RAM: expands burst
// commands into per-beat writes or wrapping reads, with a 2-entry read return buffer.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] remaining_reg, remaining_next;
  logic                  inflight_reg;
  logic                  inflight_last_reg, inflight_last_next;
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  push, pop, issue, beat, credit;
  logic [DATA_WIDTH-1:0] entry_data [2];
  logic                  entry_last [2];

  // Read data lands on ram_dout one cycle after issue, so the in-flight flag is the push strobe.
  assign push     = inflight_reg;
  assign rd_valid = (count_reg != 2'd0);
  assign pop      = rd_valid & rd_ready;
  assign credit   = ({1'b0, count_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});
  assign issue    = (state_reg == READ) && credit;
  assign beat     = (state_reg == WRITE) && wr_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  last_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= ram_dout;
          last_reg <= inflight_last_reg;
        end
      end
      assign entry_data[gi] = data_reg;
      assign entry_last[gi] = last_reg;
    end
  endgenerate

  assign rd_data   = entry_data[rd_ptr_reg];
  assign rd_last   = entry_last[rd_ptr_reg] & rd_valid;
  assign cmd_ready = (state_reg == IDLE);
  assign wr_ready  = (state_reg == WRITE);
  assign ram_we    = beat;
  assign ram_addr  = addr_reg;
  assign ram_din   = wr_data;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      remaining_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      remaining_reg     <= remaining_next;
      inflight_reg      <= issue;
      inflight_last_reg <= inflight_last_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    state_next         = state_reg;
    addr_next          = addr_reg;
    remaining_next     = remaining_reg;
    inflight_last_next = inflight_last_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next      = cmd_addr;
          remaining_next = cmd_len;
          state_next     = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (beat) begin
          addr_next = addr_reg + 1'b1;
          if (remaining_reg == '0) state_next = IDLE;
          else                     remaining_next = remaining_reg - 1'b1;
        end
      end
      READ: begin
        if (issue) begin
          addr_next          = addr_reg + 1'b1;
          inflight_last_next = (remaining_reg == '0);
          if (remaining_reg == '0) state_next = DRAIN;
          else                     remaining_next = remaining_reg - 1'b1;
        end
      end
      DRAIN: begin
        if (pop && rd_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural single-port RAM attached.
module tb_ram_burst_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] wdata  [DEPTH];
  logic          wpat   [8];
  int            wpat_n;
  logic          rpat   [8];
  int            rpat_n;

  always #5 clk = ~clk;

  // RAM: registered read returning old data on a write cycle.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int len);
    int idx;
    int cyc;
    logic [AW-1:0] ad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len[AW-1:0];
    #1 check_value("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx <= len && cyc < 64) begin
      wr_valid = wpat[cyc % wpat_n];
      wr_data  = wdata[idx];
      #1;
      check_value("wr_ready", 32'(wr_ready), 32'd1);
      check_value("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check_value("wr_ram_we", 32'(ram_we), 32'(wr_valid));
      if (wr_valid) begin
        ad = a + idx[AW-1:0];
        check_value("wr_addr", 32'(ram_addr), 32'(ad));
        check_value("wr_din", 32'(ram_din), 32'(wr_data));
        shadow[ad] = wr_data;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    #1;
    check_value("wr_beats", 32'(idx), 32'(len + 1));
    check_value("wr_busy_after", 32'(busy), 32'd0);
    check_value("wr_we_after", 32'(ram_we), 32'd0);
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int len);
    int idx;
    int k;
    int first_k;
    logic stalled;
    logic [DW-1:0] held_data;
    logic held_last;
    logic [AW-1:0] ad;
    @(negedge clk);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len[AW-1:0];
    #1 check_value("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    k = 0;
    first_k = -1;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (idx <= len && k < 200) begin
      rd_ready = rpat[k % rpat_n];
      #1;
      check_value("rd_busy", 32'(busy), 32'd1);
      if (stalled) begin
        check_value("rd_hold_valid", 32'(rd_valid), 32'd1);
        check_value("rd_hold_data", 32'(rd_data), 32'(held_data));
        check_value("rd_hold_last", 32'(rd_last), 32'(held_last));
      end
      if (rd_valid && first_k < 0) first_k = k;
      if (rd_valid && rd_ready) begin
        ad = a + idx[AW-1:0];
        check_value("rd_data", 32'(rd_data), 32'(shadow[ad]));
        check_value("rd_last", 32'(rd_last), 32'(idx == len));
        idx++;
      end
      stalled   = rd_valid && !rd_ready;
      held_data = rd_data;
      held_last = rd_last;
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    #1;
    check_value("rd_beats", 32'(idx), 32'(len + 1));
    check_value("rd_first_latency", 32'(first_k), 32'd2);
    check_value("rd_busy_after", 32'(busy), 32'd0);
    check_value("rd_valid_after", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_value("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_value("rst_rd_last", 32'(rd_last), 32'd0);
    check_value("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_value("rst_ram_we", 32'(ram_we), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // Full-depth fill: len = DEPTH-1 touches every location once.
    for (int i = 0; i < DEPTH; i++) wdata[i] = 8'h40 + 8'(i);
    wpat[0] = 1'b1; wpat_n = 1;
    rpat[0] = 1'b1; rpat_n = 1;
    write_burst(4'h0, 15);

    wdata[0] = 8'hA1; wdata[1] = 8'hA2; wdata[2] = 8'hA3; wdata[3] = 8'hA4;
    write_burst(4'h2, 3);
    read_burst(4'h2, 3);

    wdata[0] = 8'h11; wdata[1] = 8'h12; wdata[2] = 8'h13; wdata[3] = 8'h14;
    write_burst(4'hE, 3);
    read_burst(4'hE, 3);

    // Backpressure: expect A1..A4, 46, 47.
    rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1; rpat_n = 4;
    read_burst(4'h2, 5);

    wpat[0] = 1'b1; wpat[1] = 1'b0; wpat[2] = 1'b1;
    wpat[3] = 1'b1; wpat[4] = 1'b0; wpat[5] = 1'b1; wpat_n = 6;
    wdata[0] = 8'h51; wdata[1] = 8'h52; wdata[2] = 8'h53; wdata[3] = 8'h54;
    write_burst(4'h8, 3);
    rpat[0] = 1'b1; rpat_n = 1;
    read_burst(4'h8, 3);
    read_burst(4'h0, 15);

    // Reset mid-read with two reads issued and rd_ready held low.
    @(negedge clk);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2; cmd_len = 4'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_value("mid_rd_valid", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_value("abort_rd_valid", 32'(rd_valid), 32'd0);
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check_value("abort_ram_we", 32'(ram_we), 32'd0);
    rst_n = 1'b1;
    read_burst(4'h2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
